// File: rtl/free_ptr_allocator.sv
// rtl/free_ptr_allocator.sv - free data-table address pool for the hash table engine
// Optional alloc-mask double-free detection is built when FREE_PTR_DOUBLE_FREE_CHECK_EN is defined.
module free_ptr_allocator #(
  parameter int A_WIDTH = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               init_done_o,
  output logic               alloc_val_o,
  output logic [A_WIDTH-1:0] alloc_ptr_o,
  input  logic               alloc_rd_i,
  input  logic               free_en_i,
  input  logic [A_WIDTH-1:0] free_ptr_i,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               overflow_err_o,
  output logic               double_free_err_o
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam logic [A_WIDTH:0]   CNT_FULL = (A_WIDTH+1)'(DEPTH);
  localparam logic [A_WIDTH:0]   CNT_ONE  = (A_WIDTH+1)'(1);
  localparam logic [A_WIDTH-1:0] PTR_ONE  = A_WIDTH'(1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] mem_q [DEPTH];
  logic [A_WIDTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [A_WIDTH:0]   count_q;
  logic               overflow_q;

  logic init_wr;
  logic is_full;
  logic pop;
  logic push_req;
  logic push_known;
  logic push;
  logic ovf_hit;

  // INIT walks wr_ptr across every slot once; the last write hands over to READY
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:  if (wr_ptr_q == '1) state_d = ST_READY;
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  // state register; any reset restarts the fill from address 0
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  assign init_wr     = (state_q == ST_INIT);
  assign init_done_o = (state_q == ST_READY);
  assign is_full     = (count_q == CNT_FULL);

  // full is judged on the pre-cycle count, so a same-cycle pop never rescues a push
  assign pop      = alloc_rd_i & alloc_val_o;
  assign push_req = free_en_i & init_done_o;
  assign ovf_hit  = push_req & is_full;
  assign push     = push_req & ~is_full & push_known;

  assign alloc_val_o = init_done_o & (count_q != '0);
  assign alloc_ptr_o = mem_q[rd_ptr_q];
  assign free_cnt_o  = count_q;

  // pointers and occupancy; INIT counts up to full while wr_ptr wraps back to 0
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (init_wr) begin
      wr_ptr_q <= wr_ptr_q + PTR_ONE;
      count_q  <= count_q + CNT_ONE;
    end else begin
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // pool storage; written entries only show on alloc_ptr_o once rd_ptr reaches them
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (init_wr)   mem_q[wr_ptr_q] <= wr_ptr_q;
      else if (push) mem_q[wr_ptr_q] <= free_ptr_i;
    end
  end

  // sticky overflow flag, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i)        overflow_q <= 1'b0;
    else if (ovf_hit) overflow_q <= 1'b1;
  end

  assign overflow_err_o = overflow_q;

`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
  logic [DEPTH-1:0] alloc_mask_q;
  logic             dfree_q;
  logic             dfree_hit;

  // a release is only honoured for an address currently handed out
  assign push_known = alloc_mask_q[free_ptr_i];
  assign dfree_hit  = push_req & ~is_full & ~push_known;

  // track handed-out addresses; pop marks, accepted release clears
  always_ff @(posedge clk_i) begin
    if (rst_i || init_wr) begin
      alloc_mask_q <= '0;
    end else begin
      if (push) alloc_mask_q[free_ptr_i] <= 1'b0;
      if (pop)  alloc_mask_q[rd_ptr_q]   <= 1'b1;
    end
  end

  // sticky double-free flag, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i)          dfree_q <= 1'b0;
    else if (dfree_hit) dfree_q <= 1'b1;
  end

  assign double_free_err_o = dfree_q;
`else
  assign push_known        = 1'b1;
  assign double_free_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_free_ptr_allocator.sv
// tb/tb_free_ptr_allocator.sv - scoreboard bench for free_ptr_allocator with a queue-based pool model
module tb_free_ptr_allocator;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          alloc_val;
  logic [AW-1:0] alloc_ptr;
  logic          alloc_rd;
  logic          free_en;
  logic [AW-1:0] free_ptr;
  logic [AW:0]   free_cnt;
  logic          ovf_err;
  logic          dfr_err;

  free_ptr_allocator #(.A_WIDTH(AW)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .init_done_o       (init_done),
    .alloc_val_o       (alloc_val),
    .alloc_ptr_o       (alloc_ptr),
    .alloc_rd_i        (alloc_rd),
    .free_en_i         (free_en),
    .free_ptr_i        (free_ptr),
    .free_cnt_o        (free_cnt),
    .overflow_err_o    (ovf_err),
    .double_free_err_o (dfr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit done;
    bit val;
    int ptr;
    int cnt;
    bit ovf;
    bit dfr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model: the pool is a plain FIFO of addresses, outst lists handed-out ones
  int pool[$];
  int outst[$];
  bit amask[DEPTH];
  int init_left;
  bit m_ovf;
  bit m_dfr;

  function automatic void model_step(bit r, bit rd, bit fen, int fp);
    bit do_pop;
    bit do_push;
    int pv;
    if (r) begin
      init_left = DEPTH;
      pool.delete();
      outst.delete();
      m_ovf = 0;
      m_dfr = 0;
      for (int i = 0; i < DEPTH; i++) amask[i] = 0;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0)
        for (int i = 0; i < DEPTH; i++) pool.push_back(i);
    end else begin
      do_pop  = rd && (pool.size() > 0);
      do_push = 0;
      if (fen) begin
        if (pool.size() == DEPTH)     m_ovf = 1;
        else if (CHK && !amask[fp])   m_dfr = 1;
        else                          do_push = 1;
      end
      if (do_pop) begin
        pv = pool.pop_front();
        amask[pv] = 1;
        outst.push_back(pv);
      end
      if (do_push) begin
        pool.push_back(fp);
        amask[fp] = 0;
        for (int i = 0; i < outst.size(); i++)
          if (outst[i] == fp) begin
            outst.delete(i);
            break;
          end
      end
    end
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.done = (init_left == 0);
    e.val  = e.done && (pool.size() > 0);
    e.ptr  = (pool.size() > 0) ? pool[0] : 0;
    e.cnt  = pool.size();
    e.ovf  = m_ovf;
    e.dfr  = m_dfr;
    return e;
  endfunction

  // drive one cycle; after the edge the model absorbs the same inputs and queues its prediction
  task automatic cyc(input bit r, input bit rd, input bit fen, input int fp);
    rst      = r;
    alloc_rd = rd;
    free_en  = fen;
    free_ptr = AW'(fp);
    @(posedge clk);
    #1;
    model_step(r, rd, fen, fp);
    exp_q.push_back(snapshot());
  endtask

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // monitor: pops one prediction per cycle and compares against what the DUT presents
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("init_done", int'(init_done), int'(e.done));
      chk("overflow_err", int'(ovf_err), int'(e.ovf));
      chk("double_free_err", int'(dfr_err), int'(e.dfr));
      if (e.done) begin
        chk("alloc_val", int'(alloc_val), int'(e.val));
        chk("free_cnt", int'(free_cnt), e.cnt);
        if (e.val) chk("alloc_ptr", int'(alloc_ptr), e.ptr);
      end
    end
  end

  function automatic int pick_free();
    if (outst.size() > 0 && ($urandom % 4) != 0)
      return outst[$urandom % outst.size()];
    return int'($urandom % DEPTH);
  endfunction

  initial begin
    rst = 1'b1; alloc_rd = 1'b0; free_en = 1'b0; free_ptr = '0;

    // reset and fill
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 0);

    // drain in order, then one extra pop that must be ignored
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // release into an empty pool, then consume in FIFO order
    cyc(0, 0, 1, 5);
    cyc(0, 0, 1, 2);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);

    // refill completely, then one release too many
    for (int i = 0; i < DEPTH; i++) begin
      if (outst.size() > 0) cyc(0, 0, 1, outst[0]);
      else                  cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 1, 3);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);

    // fresh pool, occupancy 4, simultaneous pop and release
    cyc(1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, outst[0]);
    cyc(0, 0, 0, 0);

    // reset mid-traffic at occupancy 1
    for (int i = 0; i < DEPTH && pool.size() > 1; i++) cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 2);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 1, 1, 6);
    cyc(0, 0, 0, 0);

    // release of an address that was never handed out
    cyc(1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 4);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 4);
    cyc(0, 0, 0, 0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      if (($urandom % 200) == 0) cyc(1, 0, 0, 0);
      else cyc(0, ($urandom % 2) == 1, ($urandom % 3) == 0, pick_free());
    end

    rst = 1'b0; alloc_rd = 1'b0; free_en = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
